// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types and constants for the control/register-index
//                pipeline (register index width, memory-wait FSM states,
//                stage control bundle and its bubble value).
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Default register index width
  localparam int REG_W = 5;

  // Default maximum wait for a single data-memory access
  localparam int WAIT_MAX_DEF = 15;

  // Memory-wait handshake states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Per-stage control bits carried alongside the register indices
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
  } ctrl_t;

  // Control value of an inserted bubble: no architectural side effect
  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0};

  // An M-stage instruction touches data memory when it loads or stores
  function automatic logic is_mem_op(input ctrl_t c);
    return c.mem_to_reg | c.mem_write;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Generic pipeline stage register with hold and clear.
//                Priority: hold (keep contents) > clear (load zeros) > load d.
//  Ports       : clk, rst_n (async active-low), hold, clear,
//                d [WIDTH-1:0] next-stage value, q [WIDTH-1:0] stage contents
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (hold) begin
      q_d = q_q;
    end else if (clear) begin
      q_d = '0;
    end else begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipe_regs
//  Description : Control/register-index pipeline D -> E -> M -> W with a
//                data-memory wait handshake. While an M-stage access is
//                outstanding, E and M freeze and W receives bubbles; a wait
//                longer than WAIT_MAX cycles is forced complete with mem_err.
//  Ports       : clk, rst_n (async active-low)
//                D inputs : RegWriteD, MemToRegD, MemWriteD, RegDstD,
//                           RsD, RtD, RdD, FlushE, mem_ready
//                E outputs: RsE, RtE, WriteRegE, RegWriteE, MemToRegE, MemWriteE
//                M outputs: WriteRegM, RegWriteM, MemToRegM, MemWriteM
//                W outputs: WriteRegW, RegWriteW, MemToRegW
//                Memory   : mem_req, mem_stall, mem_err
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipe_regs
  import pipe_pkg::*;
#(
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter int WAIT_MAX = pipe_pkg::WAIT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             MemWriteD,
  input  logic             RegDstD,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RdD,
  input  logic             FlushE,
  input  logic             mem_ready,
  output logic [REG_W-1:0] RsE,
  output logic [REG_W-1:0] RtE,
  output logic [REG_W-1:0] WriteRegE,
  output logic             RegWriteE,
  output logic             MemToRegE,
  output logic             MemWriteE,
  output logic [REG_W-1:0] WriteRegM,
  output logic             RegWriteM,
  output logic             MemToRegM,
  output logic             MemWriteM,
  output logic [REG_W-1:0] WriteRegW,
  output logic             RegWriteW,
  output logic             MemToRegW,
  output logic             mem_req,
  output logic             mem_stall,
  output logic             mem_err
);

  localparam int                 CNT_W   = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  localparam int E_W = 3 + 3 * REG_W;
  localparam int M_W = 3 + REG_W;
  localparam int W_W = 2 + REG_W;

  // --------------------------------------------------------------------------
  // Decode-side assembly
  // --------------------------------------------------------------------------
  logic [REG_W-1:0] write_reg_d;
  ctrl_t            ctrl_d;
  ctrl_t            ctrl_e;
  ctrl_t            ctrl_m;

  assign write_reg_d = RegDstD ? RdD : RtD;
  assign ctrl_d      = '{reg_write: RegWriteD, mem_to_reg: MemToRegD, mem_write: MemWriteD};

  // --------------------------------------------------------------------------
  // Memory handshake status (combinational on current M contents)
  // --------------------------------------------------------------------------
  mem_state_e       state_q;
  mem_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mem_op_m;
  logic             timeout;

  assign mem_op_m  = is_mem_op(ctrl_m);
  assign timeout   = (state_q == WAIT) && (cnt_q == CNT_MAX);
  assign mem_req   = mem_op_m;
  // Timeout releases the freeze so the pipe advances on the same cycle the
  // error is flagged; the access is treated as completed.
  assign mem_stall = mem_op_m & ~mem_ready & ~timeout;
  assign mem_err   = timeout & mem_op_m & ~mem_ready;

  // --------------------------------------------------------------------------
  // Stage registers
  // --------------------------------------------------------------------------
  logic [E_W-1:0] e_q;
  logic [M_W-1:0] m_q;
  logic [W_W-1:0] w_q;

  // E: a stall outranks FlushE; D is frozen upstream so the flush is re-issued
  pipe_stage_reg #(.WIDTH(E_W)) u_stage_e (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_stall),
    .clear (FlushE),
    .d     ({ctrl_d, RsD, RtD, write_reg_d}),
    .q     (e_q)
  );

  assign {ctrl_e, RsE, RtE, WriteRegE} = e_q;
  assign RegWriteE = ctrl_e.reg_write;
  assign MemToRegE = ctrl_e.mem_to_reg;
  assign MemWriteE = ctrl_e.mem_write;

  pipe_stage_reg #(.WIDTH(M_W)) u_stage_m (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (mem_stall),
    .clear (1'b0),
    .d     ({ctrl_e, WriteRegE}),
    .q     (m_q)
  );

  assign {ctrl_m, WriteRegM} = m_q;
  assign RegWriteM = ctrl_m.reg_write;
  assign MemToRegM = ctrl_m.mem_to_reg;
  assign MemWriteM = ctrl_m.mem_write;

  // W: bubbles while M waits, so a load commits exactly once on completion
  pipe_stage_reg #(.WIDTH(W_W)) u_stage_w (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (1'b0),
    .clear (mem_stall),
    .d     ({ctrl_m.reg_write, ctrl_m.mem_to_reg, WriteRegM}),
    .q     (w_q)
  );

  assign {RegWriteW, MemToRegW, WriteRegW} = w_q;

  // --------------------------------------------------------------------------
  // Wait FSM and counter. The first stalled cycle happens in IDLE, so cnt
  // reaching WAIT_MAX marks WAIT_MAX stalled cycles already spent.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_op_m && !mem_ready) begin
          state_d = WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT: begin
        if (mem_ready || timeout || !mem_op_m) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipe_regs
//  Description : Self-checking bench for ctrl_pipe_regs. A slot-level model
//                (instructions in E/M, last W commit, cycles waited in M)
//                predicts every output each cycle; directed sequences add
//                literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipe_regs;

  localparam int RW   = 5;
  localparam int WMAX = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          RegWriteD, MemToRegD, MemWriteD, RegDstD;
  logic [RW-1:0] RsD, RtD, RdD;
  logic          FlushE, mem_ready;
  logic [RW-1:0] RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic          RegWriteE, MemToRegE, MemWriteE;
  logic          RegWriteM, MemToRegM, MemWriteM;
  logic          RegWriteW, MemToRegW;
  logic          mem_req, mem_stall, mem_err;

  ctrl_pipe_regs #(.REG_W(RW), .WAIT_MAX(WMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD), .RegDstD(RegDstD),
    .RsD(RsD), .RtD(RtD), .RdD(RdD), .FlushE(FlushE), .mem_ready(mem_ready),
    .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
    .mem_req(mem_req), .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rw, mtr, mw;
    logic [RW-1:0] rs, rt, wr;
  } instr_t;

  typedef struct {
    logic rw, mtr, mw, rdst;
    logic [RW-1:0] rs, rt, rd;
    logic flush, ready;
  } stim_t;

  // Model state: which instruction sits in E and M, what W last committed,
  // and how many stalled cycles the M instruction has spent so far.
  instr_t        slot_e, slot_m;
  logic          w_rw, w_mtr;
  logic [RW-1:0] w_wr;
  int            waited;
  stim_t         cur;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    slot_e = '0; slot_m = '0;
    w_rw = 1'b0; w_mtr = 1'b0; w_wr = '0;
    waited = 0;
  endtask

  function automatic logic m_memop();
    return slot_m.mtr | slot_m.mw;
  endfunction

  function automatic logic m_stall();
    return m_memop() && !cur.ready && (waited < WMAX);
  endfunction

  function automatic logic m_err();
    return m_memop() && !cur.ready && (waited == WMAX);
  endfunction

  task automatic compare_all();
    chk("RsE", RsE, slot_e.rs);
    chk("RtE", RtE, slot_e.rt);
    chk("WriteRegE", WriteRegE, slot_e.wr);
    chk("RegWriteE", RegWriteE, slot_e.rw);
    chk("MemToRegE", MemToRegE, slot_e.mtr);
    chk("MemWriteE", MemWriteE, slot_e.mw);
    chk("WriteRegM", WriteRegM, slot_m.wr);
    chk("RegWriteM", RegWriteM, slot_m.rw);
    chk("MemToRegM", MemToRegM, slot_m.mtr);
    chk("MemWriteM", MemWriteM, slot_m.mw);
    chk("WriteRegW", WriteRegW, w_wr);
    chk("RegWriteW", RegWriteW, w_rw);
    chk("MemToRegW", MemToRegW, w_mtr);
    chk("mem_req", mem_req, m_memop());
    chk("mem_stall", mem_stall, m_stall());
    chk("mem_err", mem_err, m_err());
  endtask

  task automatic apply(input stim_t x);
    cur       = x;
    RegWriteD = x.rw;  MemToRegD = x.mtr; MemWriteD = x.mw; RegDstD = x.rdst;
    RsD       = x.rs;  RtD       = x.rt;  RdD       = x.rd;
    FlushE    = x.flush; mem_ready = x.ready;
  endtask

  // Drive on the falling edge, check the settled outputs just after
  task automatic drive(input stim_t x);
    @(negedge clk);
    apply(x);
    #1;
    compare_all();
  endtask

  // Advance the model across the rising edge
  task automatic tick();
    instr_t nxt;
    @(posedge clk);
    if (m_stall()) begin
      w_rw = 1'b0; w_mtr = 1'b0; w_wr = '0;
      waited++;
    end else begin
      w_rw  = slot_m.rw; w_mtr = slot_m.mtr; w_wr = slot_m.wr;
      slot_m = slot_e;
      nxt.rw  = cur.rw;  nxt.mtr = cur.mtr; nxt.mw = cur.mw;
      nxt.rs  = cur.rs;  nxt.rt  = cur.rt;
      nxt.wr  = cur.rdst ? cur.rd : cur.rt;
      slot_e = cur.flush ? instr_t'('0) : nxt;
      waited = 0;
    end
  endtask

  function automatic stim_t nop(input logic ready);
    stim_t s;
    s.rw = 0; s.mtr = 0; s.mw = 0; s.rdst = 0;
    s.rs = '0; s.rt = '0; s.rd = '0; s.flush = 0; s.ready = ready;
    return s;
  endfunction

  function automatic stim_t rnd(input int ready_pct);
    stim_t s;
    s.rw    = 1'($urandom);
    s.mtr   = 1'($urandom);
    s.mw    = ($urandom_range(0, 3) == 0);
    s.rdst  = 1'($urandom);
    s.rs    = RW'($urandom);
    s.rt    = RW'($urandom);
    s.rd    = RW'($urandom);
    s.flush = ($urandom_range(0, 7) == 0);
    s.ready = ($urandom_range(0, 99) < ready_pct);
    return s;
  endfunction

  initial begin
    stim_t s;
    int    stalls, errs;
    int    pct_tab [4] = '{0, 30, 70, 100};

    // Reset state
    rst_n = 1'b0;
    apply(nop(1'b1));
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) rst_n = 1'b1;

    // ALU op through the pipe, single-cycle memory path
    s = nop(1'b1); s.rw = 1; s.rdst = 1; s.rd = 7; s.rt = 2;
    drive(s); tick();
    drive(nop(1'b1)); chk("alu_WriteRegE", WriteRegE, 7); tick();
    drive(nop(1'b1)); chk("alu_WriteRegM", WriteRegM, 7); chk("alu_stall", mem_stall, 0); tick();
    drive(nop(1'b1)); chk("alu_WriteRegW", WriteRegW, 7); chk("alu_RegWriteW", RegWriteW, 1); tick();

    // FlushE bubbles a valid decode instruction
    s = nop(1'b1); s.rw = 1; s.mtr = 1; s.rt = 3; s.flush = 1;
    drive(s); tick();
    drive(nop(1'b1));
    chk("flush_RegWriteE", RegWriteE, 0); chk("flush_MemToRegE", MemToRegE, 0);
    chk("flush_WriteRegE", WriteRegE, 0);
    tick();

    // Load waiting 3 cycles
    s = nop(1'b1); s.rw = 1; s.mtr = 1; s.rt = 9; s.rd = 4;
    drive(s); tick();
    drive(nop(1'b1)); tick();
    for (int i = 0; i < 3; i++) begin
      drive(nop(1'b0));
      chk("ld_stall", mem_stall, 1); chk("ld_hold_M", WriteRegM, 9); chk("ld_bubble_W", RegWriteW, 0);
      tick();
    end
    drive(nop(1'b1)); chk("ld_release", mem_stall, 0); tick();
    drive(nop(1'b1));
    chk("ld_commit_rw", RegWriteW, 1); chk("ld_commit_wr", WriteRegW, 9); chk("ld_commit_mtr", MemToRegW, 1);
    tick();
    drive(nop(1'b1)); chk("ld_once", RegWriteW, 0); tick();

    // Store that never completes: timeout
    s = nop(1'b1); s.mw = 1; s.rs = 2; s.rt = 4;
    drive(s); tick();
    drive(nop(1'b1)); tick();
    stalls = 0; errs = 0;
    for (int i = 0; i < WMAX + 3; i++) begin
      drive(nop(1'b0));
      stalls += int'(mem_stall); errs += int'(mem_err);
      tick();
    end
    chk("to_stall_cycles", stalls, WMAX);
    chk("to_err_pulses", errs, 1);
    drive(nop(1'b1)); chk("to_advanced", MemWriteM, 0); tick();

    // FlushE ignored while stalled
    s = nop(1'b1); s.rw = 1; s.mtr = 1; s.rt = 5;
    drive(s); tick();
    s = nop(1'b1); s.rw = 1; s.rdst = 1; s.rd = 12;
    drive(s); tick();
    s = nop(1'b0); s.flush = 1;
    drive(s); chk("fl_stall", mem_stall, 1); tick();
    drive(nop(1'b0)); chk("fl_keep_wr", WriteRegE, 12); chk("fl_keep_rw", RegWriteE, 1); tick();
    repeat (3) begin drive(nop(1'b1)); tick(); end

    // Reset while waiting
    s = nop(1'b1); s.rw = 1; s.mtr = 1; s.rt = 6;
    drive(s); tick();
    drive(nop(1'b1)); tick();
    drive(nop(1'b0)); tick();
    drive(nop(1'b0));
    #2 rst_n = 1'b0;
    #1 model_reset(); compare_all(); chk("rstw_err", mem_err, 0);
    @(posedge clk); #1 chk("rstw_err_edge", mem_err, 0); chk("rstw_W", WriteRegW, 0);
    @(negedge clk) rst_n = 1'b1;

    // Randomised traffic with varying memory latency
    for (int seg = 0; seg < 40; seg++) begin
      for (int c = 0; c < 50; c++) begin
        drive(rnd(pct_tab[seg % 4])); tick();
      end
    end

    // Asynchronous reset mid-cycle after random activity
    drive(rnd(50));
    #2 rst_n = 1'b0;
    #1 model_reset(); compare_all();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int c = 0; c < 500; c++) begin
      drive(rnd(int'($urandom_range(0, 100)))); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
